// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap controller: CSR addresses,
// trap cause codes, mstatus/mie bit positions and the controller state enum.
package trap_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam logic [63:0] CAUSE_MTI     = 64'h8000_0000_0000_0007;
  localparam logic [63:0] CAUSE_ECALL_M = 64'd11;

  localparam int BIT_MIE  = 3;
  localparam int BIT_MPIE = 7;
  localparam int BIT_MTIE = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTER = 2'd1,
    ST_EXIT  = 2'd2
  } state_e;

  function automatic logic [63:0] mtvec_base(input logic [63:0] mtvec);
    return {mtvec[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/trap_csr_file.sv
// Machine trap CSR storage (mstatus.MIE/MPIE, mie.MTIE, mtvec, mepc, mcause),
// combinational read mux and the derived trap/return redirect targets.
// Optional macro TRAP_VECTORED_EN: keeps mtvec[1:0] writable and, in mode 1,
// sends interrupts to base + 4*cause code. Without it mtvec[1:0] stay 0.
module trap_csr_file
  import trap_pkg::*;
#(
  parameter logic [63:0] RESET_MTVEC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csr_wen,
  input  logic [11:0] csr_addr,
  input  logic [63:0] csr_wdata,
  input  logic        timer_irq,
  input  logic        trap_en,
  input  logic [63:0] trap_cause,
  input  logic [63:0] trap_pc,
  input  logic        mret_en,
  output logic [63:0] rdata,
  output logic        mstatus_mie,
  output logic        mie_mtie,
  output logic [63:0] trap_vec,
  output logic [63:0] ret_pc
);

  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;
  logic        mtie_q, mtie_d;
  logic [63:0] mtvec_q, mtvec_d;
  logic [63:0] mepc_q, mepc_d;
  logic [63:0] mcause_q, mcause_d;
  logic        sys_upd;

  // Next CSR values: software write first, then trap/mret side effects override.
  always_comb begin
    mie_d    = mie_q;
    mpie_d   = mpie_q;
    mtie_d   = mtie_q;
    mtvec_d  = mtvec_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    sys_upd  = trap_en | mret_en;
    if (csr_wen) begin
      case (csr_addr)
        CSR_MSTATUS: if (!sys_upd) begin
          mie_d  = csr_wdata[BIT_MIE];
          mpie_d = csr_wdata[BIT_MPIE];
        end
        CSR_MIE:     mtie_d = csr_wdata[BIT_MTIE];
`ifdef TRAP_VECTORED_EN
        CSR_MTVEC:   mtvec_d = csr_wdata;
`else
        CSR_MTVEC:   mtvec_d = mtvec_base(csr_wdata);
`endif
        CSR_MEPC:    if (!sys_upd) mepc_d = {csr_wdata[63:1], 1'b0};
        CSR_MCAUSE:  if (!sys_upd) mcause_d = csr_wdata;
        default:     ;
      endcase
    end
    if (trap_en) begin
      mepc_d   = trap_pc;
      mcause_d = trap_cause;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret_en) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end
  end

  // CSR registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      mtie_q   <= 1'b0;
      mtvec_q  <= RESET_MTVEC;
      mepc_q   <= '0;
      mcause_q <= '0;
    end else begin
      mie_q    <= mie_d;
      mpie_q   <= mpie_d;
      mtie_q   <= mtie_d;
      mtvec_q  <= mtvec_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
    end
  end

  // Read mux; unmapped addresses return zero.
  always_comb begin
    rdata = '0;
    case (csr_addr)
      CSR_MSTATUS: begin
        rdata[BIT_MIE]  = mie_q;
        rdata[BIT_MPIE] = mpie_q;
      end
      CSR_MIE:     rdata[BIT_MTIE] = mtie_q;
      CSR_MTVEC:   rdata = mtvec_q;
      CSR_MEPC:    rdata = mepc_q;
      CSR_MCAUSE:  rdata = mcause_q;
      CSR_MIP:     rdata[BIT_MTIE] = timer_irq;
      default:     rdata = '0;
    endcase
  end

  // Redirect targets; mcause already holds the trap cause while entering.
  always_comb begin
    trap_vec = mtvec_base(mtvec_q);
`ifdef TRAP_VECTORED_EN
    if (mtvec_q[1:0] == 2'b01 && mcause_q[63])
      trap_vec = mtvec_base(mtvec_q) + {mcause_q[61:0], 2'b00};
`endif
    ret_pc = {mepc_q[63:1], 1'b0};
  end

  assign mstatus_mie = mie_q;
  assign mie_mtie    = mtie_q;

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: takes timer interrupts, ECALL and MRET at the
// commit boundary and issues a held fetch redirect while stalling the pipe.
// Optional macro TRAP_VECTORED_EN enables vectored interrupt entry (see
// trap_csr_file).
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | normal execution, commits and CSR writes accepted
// ST_ENTER | trap taken, redirect to trap vector pending, pipeline stalled
// ST_EXIT  | mret taken, redirect to mepc pending, pipeline stalled
module trap_ctrl
  import trap_pkg::*;
#(
  parameter logic [63:0] RESET_MTVEC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_timer_irq,
  input  logic        i_commit_valid,
  input  logic [63:0] i_commit_pc,
  input  logic        i_ecall,
  input  logic        i_mret,
  input  logic        i_csr_wen,
  input  logic [11:0] i_csr_addr,
  input  logic [63:0] i_csr_wdata,
  output logic [63:0] o_csr_rdata,
  output logic        o_redirect_valid,
  output logic [63:0] o_redirect_pc,
  input  logic        i_redirect_ready,
  output logic        o_stall
);

  state_e      state_q, state_d;
  logic        csr_we;
  logic        trap_en;
  logic        mret_en;
  logic [63:0] trap_cause;
  logic        mstatus_mie;
  logic        mie_mtie;
  logic        irq_take;
  logic [63:0] trap_vec;
  logic [63:0] ret_pc;

  trap_csr_file #(.RESET_MTVEC(RESET_MTVEC)) u_csr (
    .clk         (clk),
    .rst_n       (rst_n),
    .csr_wen     (csr_we),
    .csr_addr    (i_csr_addr),
    .csr_wdata   (i_csr_wdata),
    .timer_irq   (i_timer_irq),
    .trap_en     (trap_en),
    .trap_cause  (trap_cause),
    .trap_pc     (i_commit_pc),
    .mret_en     (mret_en),
    .rdata       (o_csr_rdata),
    .mstatus_mie (mstatus_mie),
    .mie_mtie    (mie_mtie),
    .trap_vec    (trap_vec),
    .ret_pc      (ret_pc)
  );

  assign irq_take = i_timer_irq & mstatus_mie & mie_mtie;

  // Next state, trap/mret strobes and redirect outputs; all quiet during reset.
  always_comb begin
    state_d          = state_q;
    csr_we           = 1'b0;
    trap_en          = 1'b0;
    mret_en          = 1'b0;
    trap_cause       = CAUSE_ECALL_M;
    o_redirect_valid = 1'b0;
    o_redirect_pc    = '0;
    o_stall          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        csr_we = i_csr_wen;
        if (i_commit_valid) begin
          if (irq_take) begin
            trap_en    = 1'b1;
            trap_cause = CAUSE_MTI;
            state_d    = ST_ENTER;
          end else if (i_ecall) begin
            trap_en    = 1'b1;
            trap_cause = CAUSE_ECALL_M;
            state_d    = ST_ENTER;
          end else if (i_mret) begin
            mret_en = 1'b1;
            state_d = ST_EXIT;
          end
        end
      end
      ST_ENTER: begin
        o_redirect_valid = 1'b1;
        o_redirect_pc    = trap_vec;
        o_stall          = 1'b1;
        if (i_redirect_ready) state_d = ST_IDLE;
      end
      ST_EXIT: begin
        o_redirect_valid = 1'b1;
        o_redirect_pc    = ret_pc;
        o_stall          = 1'b1;
        if (i_redirect_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (!rst_n) begin
      csr_we           = 1'b0;
      trap_en          = 1'b0;
      mret_en          = 1'b0;
      o_redirect_valid = 1'b0;
      o_redirect_pc    = '0;
      o_stall          = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios with literal expectations plus a
// cycle-level reference model of the architectural trap behaviour that is
// compared against the DUT on every falling edge.
module tb_trap_ctrl;

  localparam logic [63:0] RST_VEC   = 64'h8000_0000;
  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MIP     = 12'h344;
  localparam logic [63:0] C_MTI     = 64'h8000_0000_0000_0007;
`ifdef TRAP_VECTORED_EN
  localparam bit VEC = 1'b1;
`else
  localparam bit VEC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_timer_irq, i_commit_valid, i_ecall, i_mret;
  logic [63:0] i_commit_pc;
  logic        i_csr_wen;
  logic [11:0] i_csr_addr;
  logic [63:0] i_csr_wdata;
  logic [63:0] o_csr_rdata;
  logic        o_redirect_valid;
  logic [63:0] o_redirect_pc;
  logic        i_redirect_ready;
  logic        o_stall;

  always #10 clk = ~clk;

  trap_ctrl #(.RESET_MTVEC(RST_VEC)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_timer_irq      (i_timer_irq),
    .i_commit_valid   (i_commit_valid),
    .i_commit_pc      (i_commit_pc),
    .i_ecall          (i_ecall),
    .i_mret           (i_mret),
    .i_csr_wen        (i_csr_wen),
    .i_csr_addr       (i_csr_addr),
    .i_csr_wdata      (i_csr_wdata),
    .o_csr_rdata      (o_csr_rdata),
    .o_redirect_valid (o_redirect_valid),
    .o_redirect_pc    (o_redirect_pc),
    .i_redirect_ready (i_redirect_ready),
    .o_stall          (o_stall)
  );

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural view (enable bits, CSR values, pending redirect).
  bit          m_init = 1'b0;
  bit          m_busy, m_mie, m_mpie, m_mtie;
  logic [63:0] m_mtvec, m_mepc, m_mcause, m_target;

  function automatic logic [63:0] m_read(input logic [11:0] a);
    case (a)
      A_MSTATUS: return (m_mie ? 64'h8 : 64'h0) | (m_mpie ? 64'h80 : 64'h0);
      A_MIE:     return m_mtie ? 64'h80 : 64'h0;
      A_MTVEC:   return m_mtvec;
      A_MEPC:    return m_mepc;
      A_MCAUSE:  return m_mcause;
      A_MIP:     return i_timer_irq ? 64'h80 : 64'h0;
      default:   return 64'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    bit          irq, trap, ret;
    logic [63:0] base;
    if (!rst_n) begin
      m_init = 1'b1; m_busy = 1'b0; m_target = 0;
      m_mie = 1'b0; m_mpie = 1'b0; m_mtie = 1'b0;
      m_mtvec = RST_VEC; m_mepc = 0; m_mcause = 0;
    end else if (m_busy) begin
      if (i_redirect_ready) m_busy = 1'b0;
    end else begin
      irq  = i_timer_irq && m_mie && m_mtie;
      trap = i_commit_valid && (irq || i_ecall);
      ret  = i_commit_valid && !trap && i_mret;
      if (i_csr_wen) begin
        if (i_csr_addr == A_MSTATUS && !trap && !ret) begin
          m_mie = i_csr_wdata[3]; m_mpie = i_csr_wdata[7];
        end
        if (i_csr_addr == A_MIE) m_mtie = i_csr_wdata[7];
        if (i_csr_addr == A_MTVEC) m_mtvec = VEC ? i_csr_wdata : (i_csr_wdata & ~64'h3);
        if (i_csr_addr == A_MEPC && !trap && !ret) m_mepc = i_csr_wdata & ~64'h1;
        if (i_csr_addr == A_MCAUSE && !trap && !ret) m_mcause = i_csr_wdata;
      end
      if (trap) begin
        m_mepc   = i_commit_pc;
        m_mcause = irq ? C_MTI : 64'd11;
        m_mpie   = m_mie;
        m_mie    = 1'b0;
        base     = m_mtvec & ~64'h3;
        m_target = (VEC && irq && m_mtvec % 4 == 1) ? base + 4 * 7 : base;
        m_busy   = 1'b1;
      end else if (ret) begin
        m_mie    = m_mpie;
        m_mpie   = 1'b1;
        m_target = m_mepc & ~64'h1;
        m_busy   = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (m_init) begin
      chk("model_redirect_valid", {63'b0, o_redirect_valid}, {63'b0, rst_n && m_busy});
      chk("model_redirect_pc", o_redirect_pc, (rst_n && m_busy) ? m_target : 64'h0);
      chk("model_stall", {63'b0, o_stall}, {63'b0, rst_n && m_busy});
      chk("model_csr_rdata", o_csr_rdata, m_read(i_csr_addr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input string name, input logic [11:0] a, input logic [63:0] exp);
    i_csr_addr = a;
    #1;
    chk(name, o_csr_rdata, exp);
  endtask

  task automatic chk_out(input string name, input logic ev, input logic [63:0] epc, input logic es);
    #1;
    chk({name, "_valid"}, {63'b0, o_redirect_valid}, {63'b0, ev});
    chk({name, "_pc"}, o_redirect_pc, epc);
    chk({name, "_stall"}, {63'b0, o_stall}, {63'b0, es});
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [63:0] d);
    i_csr_wen = 1'b1; i_csr_addr = a; i_csr_wdata = d;
    tick();
    i_csr_wen = 1'b0;
  endtask

  task automatic commit(input logic [63:0] pc, input logic ec, input logic mr);
    i_commit_valid = 1'b1; i_commit_pc = pc; i_ecall = ec; i_mret = mr;
    tick();
    i_commit_valid = 1'b0; i_ecall = 1'b0; i_mret = 1'b0;
  endtask

  task automatic handshake();
    i_redirect_ready = 1'b1;
    tick();
    i_redirect_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; i_timer_irq = 0; i_commit_valid = 0; i_commit_pc = 0;
    i_ecall = 0; i_mret = 0; i_csr_wen = 0; i_csr_addr = 0; i_csr_wdata = 0;
    i_redirect_ready = 0;
    tick(); tick();
    chk_out("reset", 1'b0, 64'h0, 1'b0);
    peek("mtvec_reset", A_MTVEC, 64'h8000_0000);
    rst_n = 1'b1;
    tick();

    // Timer interrupt entry
    csr_wr(A_MIE, 64'h80);
    csr_wr(A_MSTATUS, 64'h8);
    i_timer_irq = 1'b1;
    commit(64'h8000_0100, 1'b0, 1'b0);
    chk_out("irq_enter", 1'b1, 64'h8000_0000, 1'b1);
    peek("irq_mepc", A_MEPC, 64'h8000_0100);
    peek("irq_mcause", A_MCAUSE, 64'h8000_0000_0000_0007);
    peek("irq_mstatus", A_MSTATUS, 64'h80);
    i_timer_irq = 1'b0;
    tick();
    chk_out("irq_hold", 1'b1, 64'h8000_0000, 1'b1);
    handshake();
    chk_out("irq_done", 1'b0, 64'h0, 1'b0);

    // Mret with a slow fetch
    commit(64'h8000_0500, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk_out("mret_hold", 1'b1, 64'h8000_0100, 1'b1);
      tick();
    end
    chk_out("mret_last", 1'b1, 64'h8000_0100, 1'b1);
    handshake();
    chk_out("mret_done", 1'b0, 64'h0, 1'b0);
    peek("mret_mstatus", A_MSTATUS, 64'h88);

    // Masked interrupt
    csr_wr(A_MSTATUS, 64'h0);
    i_timer_irq = 1'b1;
    commit(64'h8000_0200, 1'b0, 1'b0);
    chk_out("masked", 1'b0, 64'h0, 1'b0);
    peek("masked_mip", A_MIP, 64'h80);

    // Interrupt beats ecall, then ecall alone
    csr_wr(A_MSTATUS, 64'h8);
    commit(64'h8000_0300, 1'b1, 1'b0);
    chk_out("irq_ecall", 1'b1, 64'h8000_0000, 1'b1);
    peek("irq_ecall_mcause", A_MCAUSE, 64'h8000_0000_0000_0007);
    peek("irq_ecall_mepc", A_MEPC, 64'h8000_0300);
    handshake();
    i_timer_irq = 1'b0;
    commit(64'h8000_0400, 1'b1, 1'b0);
    chk_out("ecall", 1'b1, 64'h8000_0000, 1'b1);
    peek("ecall_mcause", A_MCAUSE, 64'd11);
    peek("ecall_mstatus", A_MSTATUS, 64'h0);
    csr_wr(A_MCAUSE, 64'h55);
    peek("stalled_write", A_MCAUSE, 64'd11);
    handshake();

    // Trap beats a same-cycle CSR write
    csr_wr(A_MSTATUS, 64'h8);
    i_csr_wen = 1'b1; i_csr_addr = A_MEPC; i_csr_wdata = 64'h1234;
    commit(64'h8000_0600, 1'b1, 1'b0);
    i_csr_wen = 1'b0;
    peek("collide_mepc", A_MEPC, 64'h8000_0600);
    peek("collide_mstatus", A_MSTATUS, 64'h80);
    handshake();

    // Write masking and ignored addresses
    csr_wr(A_MEPC, 64'h8000_0555);
    peek("mepc_bit0", A_MEPC, 64'h8000_0554);
    i_timer_irq = 1'b1;
    csr_wr(A_MIP, 64'h0);
    peek("mip_ro", A_MIP, 64'h80);
    i_timer_irq = 1'b0;
    csr_wr(12'h7C0, 64'hFFFF_FFFF_FFFF_FFFF);
    peek("unmapped", 12'h7C0, 64'h0);
    csr_wr(A_MIE, 64'hFFFF_FFFF_FFFF_FFFF);
    peek("mie_mask", A_MIE, 64'h80);
    csr_wr(A_MSTATUS, 64'hFFFF_FFFF_FFFF_FFFF);
    peek("mstatus_mask", A_MSTATUS, 64'h88);

    // mtvec mode bits
    csr_wr(A_MTVEC, 64'h8000_0001);
`ifdef TRAP_VECTORED_EN
    peek("mtvec_vec", A_MTVEC, 64'h8000_0001);
    i_timer_irq = 1'b1;
    commit(64'h8000_0700, 1'b0, 1'b0);
    chk_out("vec_irq", 1'b1, 64'h8000_001C, 1'b1);
    handshake();
    i_timer_irq = 1'b0;
    commit(64'h8000_0704, 1'b1, 1'b0);
    chk_out("vec_ecall", 1'b1, 64'h8000_0000, 1'b1);
    handshake();
`else
    peek("mtvec_direct", A_MTVEC, 64'h8000_0000);
    i_timer_irq = 1'b1;
    commit(64'h8000_0700, 1'b0, 1'b0);
    chk_out("direct_irq", 1'b1, 64'h8000_0000, 1'b1);
    handshake();
    i_timer_irq = 1'b0;
`endif

    // Reset while entering a trap
    csr_wr(A_MTVEC, 64'h9000_0000);
    commit(64'h8000_0800, 1'b1, 1'b0);
    chk_out("pre_reset", 1'b1, 64'h9000_0000, 1'b1);
    rst_n = 1'b0;
    chk_out("in_reset", 1'b0, 64'h0, 1'b0);
    tick();
    chk_out("after_reset", 1'b0, 64'h0, 1'b0);
    peek("reset_mtvec", A_MTVEC, 64'h8000_0000);
    peek("reset_mstatus", A_MSTATUS, 64'h0);
    rst_n = 1'b1;
    tick();
    chk_out("post_reset", 1'b0, 64'h0, 1'b0);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 The module SHALL have parameter RESET_MTVEC, default 64'h8000_0000, mtvec value loaded at reset.
REQ-002 The module SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-003 The module SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-004 The module SHALL have port i_timer_irq, input, 1, level-sensitive machine timer pending from the timer block.
REQ-005 The module SHALL have port i_commit_valid, input, 1, an instruction is at the commit boundary this cycle.
REQ-006 The module SHALL have port i_commit_pc, input, 64, PC of the committing instruction.
REQ-007 The module SHALL have ports i_ecall and i_mret, input, 1 each, committing instruction is ECALL or MRET; qualified by i_commit_valid.
REQ-008 The module SHALL have ports i_csr_wen (1), i_csr_addr (12) and i_csr_wdata (64), inputs, CSR instruction write.
REQ-009 The module SHALL have port o_csr_rdata, output, 64, combinational read data for i_csr_addr; 0 for unmapped addresses.
REQ-010 The module SHALL have ports o_redirect_valid (1) and o_redirect_pc (64), outputs, fetch redirect request.
REQ-011 The module SHALL have port i_redirect_ready, input, 1, fetch accepts the redirect.
REQ-012 The module SHALL have port o_stall, output, 1, hold the pipeline and suppress commits.

Function
REQ-013 The module SHALL implement CSRs: mstatus 0x300 (bits MIE[3] and MPIE[7] only, other bits read 0), mie 0x304 (MTIE[7] only), mtvec 0x305, mepc 0x341, mcause 0x342, and mip 0x344 (read-only, bit 7 = i_timer_irq).
REQ-014 The module SHALL define irq_take = i_timer_irq & mstatus.MIE & mie.MTIE.
REQ-015 The FSM SHALL have three states: IDLE, ENTER and EXIT.
REQ-016 In IDLE with i_commit_valid & irq_take, the module SHALL go to ENTER and, on that edge, set mepc=i_commit_pc, mcause=64'h8000_0000_0000_0007, MPIE=MIE and MIE=0; the instruction does not retire.
REQ-017 Otherwise, in IDLE with i_commit_valid & i_ecall, the module SHALL go to ENTER and set mepc=i_commit_pc, mcause=11, MPIE=MIE and MIE=0; the interrupt has priority over ecall.
REQ-018 Otherwise, in IDLE with i_commit_valid & i_mret, the module SHALL go to EXIT and set MIE=MPIE and MPIE=1.
REQ-019 In ENTER, the module SHALL drive o_redirect_valid=1 with o_redirect_pc = mtvec base, where base = mtvec with bits [1:0] cleared.
REQ-020 In EXIT, the module SHALL drive o_redirect_valid=1 with o_redirect_pc = mepc with bit 0 cleared.
REQ-021 The module SHALL hold o_redirect_valid and o_redirect_pc stable until i_redirect_ready; on a cycle with o_redirect_valid & i_redirect_ready it SHALL return to IDLE on the next edge; minimum trap latency is 1 cycle.
REQ-022 The module SHALL drive o_stall=1 whenever the state is not IDLE, and SHALL ignore commit inputs and CSR writes in those cycles.
REQ-023 In IDLE, a CSR write SHALL update the addressed CSR; if a trap or mret is taken in the same cycle, the trap or mret update SHALL win for mstatus, mepc and mcause.
REQ-024 Writes to mip and to unmapped addresses SHALL be ignored; mepc writes SHALL clear bit 0.
REQ-025 i_timer_irq deasserting while in ENTER SHALL NOT cancel the redirect.

Reset
REQ-026 On rst_n=0 the module SHALL set the FSM to IDLE, mstatus=0, mie=0, mepc=0, mcause=0 and mtvec=RESET_MTVEC, including mid-ENTER or mid-EXIT.
REQ-027 During reset the module SHALL drive o_redirect_valid=0, o_redirect_pc=0 and o_stall=0.

Configuration
REQ-028 With TRAP_VECTORED_EN defined, if mtvec[1:0]==1 then interrupt redirects SHALL target base + 4*cause code (base + 28 for the timer), and exceptions SHALL target base.
REQ-029 Without TRAP_VECTORED_EN, the module SHALL hold mtvec[1:0] at 0 on writes, and every trap SHALL target base.

Structure
REQ-030 A shared package trap_pkg SHALL hold: the CSR address constants; cause constants CAUSE_MTI and CAUSE_ECALL_M; the MIE, MPIE and MTIE bit indices; and the FSM state enum.
REQ-031 The CSR storage and read mux SHALL be a sub-module trap_csr_file; trap_ctrl SHALL hold the FSM and the redirect handshake.

Verification
REQ-032 Timer interrupt: mie=0x80, mstatus=0x8, irq=1, commit pc=0x8000_0100 -> next cycle ENTER, redirect to 0x8000_0000, mepc=0x8000_0100, mcause=0x8000_0000_0000_0007, mstatus=0x80.
REQ-033 Masked interrupt: mstatus.MIE=0, irq=1, commit -> no trap, o_stall=0, mip reads 0x80.
REQ-034 Ecall with irq taken in the same cycle -> mcause = the interrupt cause; ecall alone -> mcause=11.
REQ-035 Mret after trap: i_redirect_ready held low for 3 cycles -> valid held 3 cycles, o_redirect_pc=0x8000_0100, then mstatus=0x88.
REQ-036 Vectored mode (TRAP_VECTORED_EN): mtvec=0x8000_0001, timer trap -> redirect 0x8000_001C; ecall -> 0x8000_0000.
REQ-037 Reset asserted in ENTER -> IDLE, o_redirect_valid=0 and mtvec=RESET_MTVEC on the next cycle.
